// File: rtl/fifo_dl_if.sv
// Handshake and status bundle for the delay-line FIFO.
// The slave modport is the FIFO side and the master modport is the producer/consumer side.
interface fifo_dl_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned M_WIDTH = 8
);
    logic               i_wr;
    logic [WIDTH-1:0]   i_data;
    logic               i_rd;
    logic               i_dl_mode;
    logic [M_WIDTH:0]   i_delay;
    logic [WIDTH-1:0]   o_data;
    logic               o_valid;
    logic [M_WIDTH:0]   o_fill;
    logic               o_full;
    logic               o_empty;
    logic               o_almost_full;
    logic               o_almost_empty;
    logic               o_overflow;
    logic               o_underflow;

    modport slave (
        input  i_wr, i_data, i_rd, i_dl_mode, i_delay,
        output o_data, o_valid, o_fill, o_full, o_empty,
        output o_almost_full, o_almost_empty, o_overflow, o_underflow
    );

    modport master (
        output i_wr, i_data, i_rd, i_dl_mode, i_delay,
        input  o_data, o_valid, o_fill, o_full, o_empty,
        input  o_almost_full, o_almost_empty, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_dl.sv
// Single-clock FIFO that can also self-read as a programmable D-sample delay line.
// Its flags, including the sticky overflow and underflow flags, are derived from (M_WIDTH+1)-bit pointers.
module fifo_dl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned M_WIDTH   = 8,
    parameter int unsigned AF_THRESH = (1 << M_WIDTH) - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic      i_clk,
    input  logic      i_reset,
    fifo_dl_if.slave  bus
);
    localparam int unsigned      DEPTH   = 1 << M_WIDTH;
    localparam logic [M_WIDTH:0] DEPTH_F = (M_WIDTH + 1)'(DEPTH);
    localparam logic [M_WIDTH:0] AF_F    = (M_WIDTH + 1)'(AF_THRESH);
    localparam logic [M_WIDTH:0] AE_F    = (M_WIDTH + 1)'(AE_THRESH);
    localparam logic [M_WIDTH:0] ONE_F   = (M_WIDTH + 1)'(1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [M_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic [M_WIDTH:0]   fill, deff;
    logic               full, empty, rd_req, rd_acc, wr_acc;

    always_comb begin
        fill  = wr_ptr_q - rd_ptr_q;
        full  = (fill == DEPTH_F);
        empty = (fill == '0);

        if (bus.i_delay == '0) begin
            deff = ONE_F;
        end else if (bus.i_delay > DEPTH_F) begin
            deff = DEPTH_F;
        end else begin
            deff = bus.i_delay;
        end

        // Delay-line mode keeps exactly deff words stored, reading only to hold or trim that level.
        if (bus.i_dl_mode) begin
            rd_req = (fill > deff) || (bus.i_wr && (fill == deff));
        end else begin
            rd_req = bus.i_rd;
        end

        rd_acc = rd_req && !empty;
        wr_acc = bus.i_wr && (!full || rd_acc);

        wr_ptr_d = wr_acc ? wr_ptr_q + ONE_F : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ONE_F : rd_ptr_q;
        data_d   = rd_acc ? mem_q[rd_ptr_q[M_WIDTH-1:0]] : data_q;
        valid_d  = rd_acc;
        ovf_d    = ovf_q || (bus.i_wr && !wr_acc);
        unf_d    = unf_q || (!bus.i_dl_mode && rd_req && empty);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset. When the FIFO is full, a read of the same slot sees the word stored before this cycle's write.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_reset) begin
            mem_q[wr_ptr_q[M_WIDTH-1:0]] <= bus.i_data;
        end
    end

    always_comb begin
        bus.o_data         = data_q;
        bus.o_valid        = valid_q;
        bus.o_fill         = fill;
        bus.o_full         = full;
        bus.o_empty        = empty;
        bus.o_almost_full  = (fill >= AF_F);
        bus.o_almost_empty = (fill <= AE_F);
        bus.o_overflow     = ovf_q;
        bus.o_underflow    = unf_q;
    end
endmodule
